// File: rtl/fpu_mul_nrm_rnd_pipe.sv
// Multiply fraction post-normalise / denormalise / round pipeline.
// S1 shifts the raw product and folds the low bits into a sticky bit,
// S2 picks the rounding increment for the active precision and rounding mode,
// S3 adds the increment and applies the overflow override.
// Optional: define FPU_MUL_NX_CNT_EN to add a saturating inexact-result counter.
module fpu_mul_nrm_rnd_pipe #(
    parameter int unsigned FRAC_W = 52,
    parameter int unsigned SNG_W  = 23,
    parameter int unsigned SH_W   = 7,
    localparam int unsigned PW    = 2 * FRAC_W + 2,
    localparam int unsigned NW    = FRAC_W + 3
) (
    input  logic              rclk,
    input  logic              arst,
    input  logic              step,
    input  logic              flush,
    input  logic              in_vld,
    input  logic [PW-1:0]     in_prod,
    input  logic [SH_W-1:0]   in_sh_cnt,
    input  logic              in_shr,
    input  logic              in_sng,
    input  logic [1:0]        in_rmode,
    input  logic              in_sign,
    input  logic              in_of,
    input  logic              in_to_max,
`ifdef FPU_MUL_NX_CNT_EN
    input  logic              nx_cnt_clr,
    output logic [15:0]       nx_cnt,
`endif
    output logic              out_vld,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_cout,
    output logic              out_msb,
    output logic              out_nx,
    output logic              out_neq0
);

    // Offset of the narrow-precision ulp inside the wide fraction field.
    localparam int unsigned SNG_OFF = FRAC_W - SNG_W;
    localparam logic [SH_W:0] PW_CNT = (SH_W + 1)'(PW);
    localparam logic [FRAC_W-1:0] SNG_KEEP = {{SNG_W{1'b1}}, {SNG_OFF{1'b0}}};
    localparam logic [FRAC_W-1:0] SNG_ULP = FRAC_W'(1) << SNG_OFF;
    localparam logic [FRAC_W-1:0] DBL_ULP = FRAC_W'(1);

    localparam logic [1:0] RM_RN = 2'b00;
    localparam logic [1:0] RM_RZ = 2'b01;
    localparam logic [1:0] RM_RP = 2'b10;
    localparam logic [1:0] RM_RM = 2'b11;

    logic v1, v2, v3;

    // S1 state
    logic [NW-1:0] s1_norm;
    logic          s1_msb;
    logic          s1_sng;
    logic [1:0]    s1_rmode;
    logic          s1_sign;
    logic          s1_of;
    logic          s1_to_max;

    // S2 state
    logic [FRAC_W-1:0] s2_frac;
    logic              s2_inc;
    logic              s2_nx;
    logic              s2_neq0;
    logic              s2_msb;
    logic              s2_sng;
    logic              s2_of;
    logic              s2_to_max;

    // S1 combinational
    logic [2*PW-1:0] shr_wide;
    logic [PW-1:0]   sh_t;
    logic            sh_lost;
    logic            s1_msb_d;
    logic [NW-1:0]   s1_norm_d;

    // S2 combinational
    logic              rd_lsb, rd_g, rd_r, rd_s, rd_x;
    logic              s2_inc_d;
    logic [FRAC_W-1:0] s2_frac_d;

    // S3 combinational
    logic [FRAC_W-1:0] ulp;
    logic [FRAC_W:0]   sum;
    logic [FRAC_W-1:0] s3_frac_d;
    logic              s3_cout_d;

    // Valid tracking; flush wins over step.
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (step) begin
            v1 <= in_vld;
            v2 <= v1;
            v3 <= v2;
        end
    end

    assign out_vld = v3;

    // S1: shift product, keep bits dropped off the bottom as sticky, pick the normalised window.
    always_comb begin
        // Product on top of a zero field so right-shifted-out bits land in the low half.
        shr_wide = {in_prod, {PW{1'b0}}} >> in_sh_cnt;
        sh_t     = '0;
        sh_lost  = 1'b0;
        if ({1'b0, in_sh_cnt} >= PW_CNT) begin
            sh_t    = '0;
            sh_lost = |in_prod;
        end else if (in_shr) begin
            sh_t    = shr_wide[2*PW-1:PW];
            sh_lost = |shr_wide[PW-1:0];
        end else begin
            sh_t = in_prod << in_sh_cnt;
        end
        s1_msb_d = sh_t[PW-1];
        if (s1_msb_d) begin
            s1_norm_d = {sh_t[PW-2:PW-NW], (|sh_t[PW-NW-1:0]) | sh_lost};
        end else begin
            s1_norm_d = {sh_t[PW-3:PW-NW-1], (|sh_t[PW-NW-2:0]) | sh_lost};
        end
    end

    // S1 registers.
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            s1_norm   <= '0;
            s1_msb    <= 1'b0;
            s1_sng    <= 1'b0;
            s1_rmode  <= 2'b00;
            s1_sign   <= 1'b0;
            s1_of     <= 1'b0;
            s1_to_max <= 1'b0;
        end else if (step) begin
            s1_norm   <= s1_norm_d;
            s1_msb    <= s1_msb_d;
            s1_sng    <= in_sng;
            s1_rmode  <= in_rmode;
            s1_sign   <= in_sign;
            s1_of     <= in_of;
            s1_to_max <= in_to_max;
        end
    end

    // S2: locate lsb/guard/round/sticky for the active precision and decide the increment.
    always_comb begin
        if (s1_sng) begin
            rd_lsb    = s1_norm[SNG_OFF+3];
            rd_g      = s1_norm[SNG_OFF+2];
            rd_r      = s1_norm[SNG_OFF+1];
            rd_s      = |s1_norm[SNG_OFF:0];
            s2_frac_d = s1_norm[NW-1:3] & SNG_KEEP;
        end else begin
            rd_lsb    = s1_norm[3];
            rd_g      = s1_norm[2];
            rd_r      = s1_norm[1];
            rd_s      = s1_norm[0];
            s2_frac_d = s1_norm[NW-1:3];
        end
        rd_x = rd_g | rd_r | rd_s;
        case (s1_rmode)
            RM_RN:   s2_inc_d = rd_g & (rd_lsb | rd_r | rd_s);
            RM_RZ:   s2_inc_d = 1'b0;
            RM_RP:   s2_inc_d = ~s1_sign & rd_x;
            RM_RM:   s2_inc_d = s1_sign & rd_x;
            default: s2_inc_d = 1'b0;
        endcase
    end

    // S2 registers.
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            s2_frac   <= '0;
            s2_inc    <= 1'b0;
            s2_nx     <= 1'b0;
            s2_neq0   <= 1'b0;
            s2_msb    <= 1'b0;
            s2_sng    <= 1'b0;
            s2_of     <= 1'b0;
            s2_to_max <= 1'b0;
        end else if (step) begin
            s2_frac   <= s2_frac_d;
            s2_inc    <= s2_inc_d;
            s2_nx     <= rd_x;
            s2_neq0   <= |s1_norm;
            s2_msb    <= s1_msb;
            s2_sng    <= s1_sng;
            s2_of     <= s1_of;
            s2_to_max <= s1_to_max;
        end
    end

    // S3: add the increment at the active lsb; overflow replaces the sum.
    always_comb begin
        ulp = s2_sng ? SNG_ULP : DBL_ULP;
        sum = {1'b0, s2_frac} + {1'b0, (s2_inc ? ulp : '0)};
        if (s2_of) begin
            s3_frac_d = s2_to_max ? (s2_sng ? SNG_KEEP : '1) : '0;
            s3_cout_d = 1'b0;
        end else begin
            s3_frac_d = sum[FRAC_W-1:0];
            s3_cout_d = sum[FRAC_W];
        end
    end

    // S3 output registers.
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            out_frac <= '0;
            out_cout <= 1'b0;
            out_msb  <= 1'b0;
            out_nx   <= 1'b0;
            out_neq0 <= 1'b0;
        end else if (step) begin
            out_frac <= s3_frac_d;
            out_cout <= s3_cout_d;
            out_msb  <= s2_msb;
            out_nx   <= s2_nx;
            out_neq0 <= s2_neq0;
        end
    end

`ifdef FPU_MUL_NX_CNT_EN
    // Saturating count of inexact results entering S3; clear has priority.
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            nx_cnt <= 16'h0000;
        end else if (nx_cnt_clr) begin
            nx_cnt <= 16'h0000;
        end else if (step && v2 && s2_nx && (nx_cnt != 16'hFFFF)) begin
            nx_cnt <= nx_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_mul_nrm_rnd_pipe.sv
// Bench for fpu_mul_nrm_rnd_pipe: exact-arithmetic reference model behind a
// 3-slot step-driven delay line, checked every negedge, plus literal expectations.
module tb_fpu_mul_nrm_rnd_pipe;

    localparam int FW = 52;
    localparam int PW = 106;

    typedef struct packed {
        logic [FW-1:0] frac;
        logic          cout;
        logic          msb;
        logic          nx;
        logic          neq0;
    } res_t;

    logic          rclk = 1'b0;
    logic          arst = 1'b0;
    logic          step = 1'b0;
    logic          flush = 1'b0;
    logic          in_vld = 1'b0;
    logic [PW-1:0] in_prod = '0;
    logic [6:0]    in_sh_cnt = '0;
    logic          in_shr = 1'b0;
    logic          in_sng = 1'b0;
    logic [1:0]    in_rmode = 2'b00;
    logic          in_sign = 1'b0;
    logic          in_of = 1'b0;
    logic          in_to_max = 1'b0;
    logic          out_vld;
    logic [FW-1:0] out_frac;
    logic          out_cout, out_msb, out_nx, out_neq0;
`ifdef FPU_MUL_NX_CNT_EN
    logic          nx_cnt_clr = 1'b0;
    logic [15:0]   nx_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 rclk = ~rclk;

    fpu_mul_nrm_rnd_pipe dut (
        .rclk      (rclk),
        .arst      (arst),
        .step      (step),
        .flush     (flush),
        .in_vld    (in_vld),
        .in_prod   (in_prod),
        .in_sh_cnt (in_sh_cnt),
        .in_shr    (in_shr),
        .in_sng    (in_sng),
        .in_rmode  (in_rmode),
        .in_sign   (in_sign),
        .in_of     (in_of),
        .in_to_max (in_to_max),
`ifdef FPU_MUL_NX_CNT_EN
        .nx_cnt_clr(nx_cnt_clr),
        .nx_cnt    (nx_cnt),
`endif
        .out_vld   (out_vld),
        .out_frac  (out_frac),
        .out_cout  (out_cout),
        .out_msb   (out_msb),
        .out_nx    (out_nx),
        .out_neq0  (out_neq0)
    );

    // Reference: place the product as an exact value with 128 fraction bits,
    // then round by comparing the discarded remainder against one half-ulp.
    function automatic res_t model(input logic [PW-1:0] prod, input logic [6:0] cnt,
                                   input logic shr, input logic sng, input logic [1:0] rm,
                                   input logic sign, input logic of, input logic tm);
        logic [255:0] y, one, rem, half;
        logic [52:0]  q, sum, pmask;
        logic         nx, inc;
        int           lead, p, cut;
        res_t         r;
        one = 256'd1;
        if (shr) begin
            y = ({150'b0, prod} << 128) >> cnt;
        end else if (int'(cnt) >= PW) begin
            y = {255'b0, |prod};
        end else begin
            y = {150'b0, prod} << cnt;
            y = y & ((one << PW) - one);
            y = y << 128;
        end
        r.msb = y[233];
        lead  = r.msb ? 233 : 232;
        p     = sng ? 23 : 52;
        cut   = lead - p;
        pmask = (53'd1 << p) - 53'd1;
        rem   = y & ((one << cut) - one);
        half  = one << (cut - 1);
        q     = 53'(y >> cut) & pmask;
        nx    = (rem != 256'd0);
        case (rm)
            2'b00:   inc = (rem > half) || ((rem == half) && q[0]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = !sign && nx;
            default: inc = sign && nx;
        endcase
        sum    = q + {52'b0, inc};
        r.cout = sum[p];
        r.frac = 52'((sum & pmask) << (52 - p));
        r.nx   = nx;
        r.neq0 = ((y & ((one << lead) - one)) != 256'd0);
        if (of) begin
            r.frac = tm ? 52'(pmask << (52 - p)) : 52'd0;
            r.cout = 1'b0;
        end
        return r;
    endfunction

    res_t mp [3];
    logic mv [3];

    // Delay line: data moves on step, valids cleared by flush.
    always @(posedge rclk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < 3; i++) begin
                mp[i] <= '0;
                mv[i] <= 1'b0;
            end
        end else begin
            if (step) begin
                mp[0] <= model(in_prod, in_sh_cnt, in_shr, in_sng, in_rmode, in_sign, in_of,
                               in_to_max);
                mp[1] <= mp[0];
                mp[2] <= mp[1];
            end
            if (flush) begin
                for (int i = 0; i < 3; i++) mv[i] <= 1'b0;
            end else if (step) begin
                mv[0] <= in_vld;
                mv[1] <= mv[0];
                mv[2] <= mv[1];
            end
        end
    end

    // Literal expectation handshake from the stimulus process.
    int    lit_id = 0;
    int    seen_id = 0;
    string lit_name = "";
    res_t  lit_exp = '0;
    logic  lit_vld = 1'b0;
    bit    lit_full = 1'b0;

    // Single compare process.
    always @(negedge rclk) begin
        res_t act;
        act = {out_frac, out_cout, out_msb, out_nx, out_neq0};
        checks++;
        if ((out_vld !== mv[2]) || (act !== mp[2])) begin
            errors++;
            $display("FAIL model t=%0t vld=%b want %b got frac=%h c=%b m=%b nx=%b nz=%b want %h",
                     $time, out_vld, mv[2], out_frac, out_cout, out_msb, out_nx, out_neq0,
                     mp[2]);
        end
        if (lit_id != seen_id) begin
            seen_id = lit_id;
            checks++;
            if ((out_vld !== lit_vld) || (lit_full && (act !== lit_exp))) begin
                errors++;
                $display("FAIL %s vld=%b frac=%h c=%b m=%b nx=%b nz=%b want vld=%b %h",
                         lit_name, out_vld, out_frac, out_cout, out_msb, out_nx, out_neq0,
                         lit_vld, lit_exp);
            end
        end
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic send(input logic [PW-1:0] p, input int cnt, input bit shr, input bit sng,
                        input int rm, input bit sign, input bit of, input bit tm);
        in_prod   = p;
        in_sh_cnt = 7'(cnt);
        in_shr    = shr;
        in_sng    = sng;
        in_rmode  = 2'(rm);
        in_sign   = sign;
        in_of     = of;
        in_to_max = tm;
        in_vld    = 1'b1;
        step      = 1'b1;
        tick();
        in_vld    = 1'b0;
    endtask

    task automatic run(input int n);
        step = 1'b1;
        repeat (n) tick();
    endtask

    task automatic expect_out(input string name, input logic vld, input logic [FW-1:0] frac,
                              input logic cout, input logic msb, input logic nx,
                              input logic neq0, input bit full);
        lit_name = name;
        lit_vld  = vld;
        lit_exp  = {frac, cout, msb, nx, neq0};
        lit_full = full;
        lit_id++;
        @(negedge rclk);
        #1;
    endtask

    logic [PW-1:0] b104, b105, t2a, t2b, ones105, t4, t7;
    logic [127:0]  rnd;

    initial begin
        b104    = 106'd1 << 104;
        b105    = 106'd1 << 105;
        t2a     = b104 | (106'd1 << 51);
        t2b     = t2a | (106'd1 << 52);
        ones105 = (106'd1 << 105) - 106'd1;
        t4      = b104 | (106'd1 << 20);
        t7      = b104 | 106'd1;

        #1 arst = 1'b1;
        repeat (2) @(posedge rclk);
        #1;
        expect_out("reset", 1'b0, 52'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        arst = 1'b0;

        send(b104, 0, 0, 0, 0, 0, 0, 0); run(2);
        expect_out("t1_exact", 1'b1, 52'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(b105, 0, 0, 0, 0, 0, 0, 0); run(2);
        expect_out("t1_msb", 1'b1, 52'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send(t2a, 0, 0, 0, 0, 0, 0, 0); run(2);
        expect_out("t2_tie_even", 1'b1, 52'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send(t2b, 0, 0, 0, 0, 0, 0, 0); run(2);
        expect_out("t2_tie_odd", 1'b1, 52'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send(ones105, 0, 0, 0, 0, 0, 0, 0); run(2);
        expect_out("t3_rn_carry", 1'b1, 52'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        send(ones105, 0, 0, 0, 1, 0, 0, 0); run(2);
        expect_out("t3_rz", 1'b1, 52'hF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send(t4, 0, 0, 1, 2, 0, 0, 0); run(2);
        expect_out("t4_sng_rp", 1'b1, 52'h0_0000_2000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send(t4, 0, 0, 1, 3, 0, 0, 0); run(2);
        expect_out("t4_sng_rm", 1'b1, 52'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send(t2a, 0, 0, 0, 0, 0, 1, 1); run(2);
        expect_out("t5_of_max", 1'b1, 52'hF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send(t2a, 0, 0, 0, 0, 0, 1, 0); run(2);
        expect_out("t5_of_inf", 1'b1, 52'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send(b104, 0, 0, 1, 0, 0, 1, 1); run(2);
        expect_out("t5_of_sng", 1'b1, 52'hF_FFFF_E000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(t7, 1, 1, 0, 0, 0, 0, 0); run(2);
        expect_out("shr_sticky", 1'b1, 52'h8_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Back-to-back directed stream checked by the model.
        send(ones105, 0, 0, 1, 0, 0, 0, 0);
        send(t7, 1, 1, 0, 2, 1, 0, 0);
        send(t7, 1, 1, 0, 3, 1, 0, 0);
        send(b105, 110, 1, 0, 2, 0, 0, 0);
        send(b105, 0, 1, 1, 0, 0, 0, 0);
        send(106'h3_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5, 5, 0, 0, 0, 0, 0, 0);
        send(106'h2_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_F, 3, 1, 1, 2, 0, 0, 0);
        run(3);

        // Stall: A reaches the output and must stay there.
        send(t7, 1, 1, 0, 0, 0, 0, 0);
        send(t2b, 0, 0, 0, 0, 0, 0, 0);
        send(ones105, 0, 0, 0, 0, 0, 0, 0);
        expect_out("stall_pre", 1'b1, 52'h8_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step    = 1'b0;
        in_vld  = 1'b1;
        in_prod = '1;
        repeat (5) tick();
        expect_out("stall_hold", 1'b1, 52'h8_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        in_vld = 1'b0;
        run(1);
        expect_out("stall_next", 1'b1, 52'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        run(3);

        // Flush with step: nothing valid emerges.
        send(b104, 0, 0, 0, 0, 0, 0, 0);
        send(t2a, 0, 0, 0, 0, 0, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_out("flush", 1'b0, 52'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run(3);
        expect_out("flush_drain", 1'b0, 52'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between clock edges.
        send(ones105, 0, 0, 0, 0, 0, 0, 0); run(2);
        expect_out("pre_arst", 1'b1, 52'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        send(t2b, 0, 0, 0, 0, 0, 0, 0); run(2);
        #2 arst = 1'b1;
        expect_out("arst_async", 1'b0, 52'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        arst = 1'b0;
        send(t2b, 0, 0, 0, 0, 0, 0, 0); run(2);
        expect_out("post_arst", 1'b1, 52'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Pseudo-random vectors against the model.
        for (int i = 0; i < 40; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            send(rnd[PW-1:0] >> $urandom_range(0, 3), $urandom_range(0, 6),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)));
        end
        run(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
